// File: rtl/key_event_encoder.sv
// Debounces a key_down vector and turns confirmed press/release edges into
// one-byte events, queued and sent to a UART over a send/send_done handshake.
module key_event_encoder #(
   parameter int KEYS       = 40,
   parameter int SAMPLE_DIV = 240000,
   parameter int DEBOUNCE   = 4,
   parameter int DEPTH      = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [KEYS-1:0]          key_down,
   output logic                     send,
   output logic [7:0]               data,
   input  logic                     send_done,
   output logic [KEYS-1:0]          stable_keys,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     overflow
);
   localparam int TW = $clog2(SAMPLE_DIV);
   localparam int PW = $clog2(DEPTH);
   localparam int IW = (KEYS > 1) ? $clog2(KEYS) : 1;

   localparam logic       SCAN_IDLE = 1'b0;
   localparam logic       SCAN      = 1'b1;
   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] LOAD      = 2'd1;
   localparam logic [1:0] SEND      = 2'd2;
   localparam logic [1:0] RELEASE   = 2'd3;

   logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
   logic            tick;
   logic [KEYS-1:0] stable_q, stable_d, pending_q, pending_d;
   logic [2:0]      cnt_q [KEYS];
   logic [2:0]      cnt_d [KEYS];
   logic            scan_q, scan_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            push, do_push, pop, full;
   logic [7:0]      push_byte;
   logic [7:0]      mem_q [DEPTH];
   logic [7:0]      mem_d [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]     level_q, level_d;
   logic            ovf_q, ovf_d;
   logic [1:0]      tx_q, tx_d;
   logic [7:0]      data_q, data_d;

   assign tick = (tick_cnt_q == TW'(SAMPLE_DIV - 1));

   always_comb begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
      stable_d   = stable_q;
      pending_d  = pending_q;
      for (int i = 0; i < KEYS; i++) begin
         cnt_d[i] = cnt_q[i];
         if (tick) begin
            if (key_down[i] == stable_q[i]) begin
               cnt_d[i] = '0;
            end else if (cnt_q[i] == 3'(DEBOUNCE - 1)) begin
               cnt_d[i]     = '0;
               stable_d[i]  = ~stable_q[i];
               pending_d[i] = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] + 3'd1;
            end
         end
      end
      // Scan never overlaps a tick, so this clear cannot collide with a set above.
      if (scan_q == SCAN) pending_d[idx_q] = 1'b0;
   end

   always_comb begin
      scan_d = scan_q;
      idx_d  = idx_q;
      if (scan_q == SCAN_IDLE) begin
         if (tick) begin
            scan_d = SCAN;
            idx_d  = '0;
         end
      end else if (idx_q == IW'(KEYS - 1)) begin
         scan_d = SCAN_IDLE;
      end else begin
         idx_d = idx_q + IW'(1);
      end
   end

   assign push      = (scan_q == SCAN) && pending_q[idx_q];
   assign push_byte = {stable_q[idx_q], 7'(idx_q)};
   assign full      = (level_q == (PW+1)'(DEPTH));
   assign do_push   = push && !full;
   assign pop       = (tx_q == LOAD);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      ovf_d    = ovf_q | (push && full);
      if (do_push) begin
         mem_d[wr_ptr_q] = push_byte;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, pop})
         2'b10:   level_d = level_q + (PW+1)'(1);
         2'b01:   level_d = level_q - (PW+1)'(1);
         default: level_d = level_q;
      endcase
   end

   // RELEASE waits for send_done to drop so one long ack cannot retire two bytes.
   always_comb begin
      tx_d   = tx_q;
      data_d = data_q;
      case (tx_q)
         IDLE:    if (level_q != '0) tx_d = LOAD;
         LOAD: begin
            data_d = mem_q[rd_ptr_q];
            tx_d   = SEND;
         end
         SEND:    if (send_done) tx_d = RELEASE;
         default: if (!send_done) tx_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_cnt_q <= '0;
         stable_q   <= '0;
         pending_q  <= '0;
         for (int i = 0; i < KEYS; i++) cnt_q[i] <= '0;
         scan_q     <= SCAN_IDLE;
         idx_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         ovf_q      <= 1'b0;
         tx_q       <= IDLE;
         data_q     <= '0;
      end else begin
         tick_cnt_q <= tick_cnt_d;
         stable_q   <= stable_d;
         pending_q  <= pending_d;
         for (int i = 0; i < KEYS; i++) cnt_q[i] <= cnt_d[i];
         scan_q     <= scan_d;
         idx_q      <= idx_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         ovf_q      <= ovf_d;
         tx_q       <= tx_d;
         data_q     <= data_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign send        = (tx_q == SEND);
   assign data        = data_q;
   assign stable_keys = stable_q;
   assign fifo_level  = level_q;
   assign overflow    = ovf_q;
endmodule

// File: tb/tb_key_event_encoder.sv
// Self-checking bench for key_event_encoder: table-driven key patterns with an
// expected-byte scoreboard, plus hand-written overflow, long-ack and reset sequences.
module tb_key_event_encoder;
   localparam int KEYS = 40;
   localparam int SDIV = 64;
   localparam int DEPTH = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [KEYS-1:0] key_down;
   logic            send;
   logic [7:0]      data;
   logic            send_done;
   logic [KEYS-1:0] stable_keys;
   logic [2:0]      fifo_level;
   logic            overflow;

   key_event_encoder #(.KEYS(KEYS), .SAMPLE_DIV(SDIV), .DEBOUNCE(3), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .key_down(key_down), .send(send), .data(data),
      .send_done(send_done), .stable_keys(stable_keys), .fifo_level(fifo_level),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [KEYS-1:0] keys;
      int              cycles;
      logic [KEYS-1:0] exp_stable;
      int              n_ev;
      logic [23:0]     evs;
   } row_t;

   row_t       rows [8];
   logic [7:0] exp_q [$];
   logic [7:0] got_q [$];
   int         total = 0;
   int         bad = 0;
   logic       auto_ack = 1'b1;
   logic       man_ack = 1'b0;
   logic       send_prev;

   // Byte collector and acknowledge driver.
   initial begin
      send_prev = 1'b0;
      send_done = 1'b0;
      forever begin
         @(negedge clk);
         if (send && !send_prev) got_q.push_back(data);
         send_prev = send;
         send_done = auto_ack ? send : man_ack;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic compare_events(input string name);
      logic [7:0] e, g;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (got_q.size() == 0) begin
            total++; bad++;
            $display("FAIL %s: missing byte, got none expected %0h", name, e);
         end else begin
            g = got_q.pop_front();
            chk(name, 64'(g), 64'(e));
         end
      end
      while (got_q.size() > 0) begin
         g = got_q.pop_front();
         total++; bad++;
         $display("FAIL %s: extra byte %0h expected none", name, g);
      end
   endtask

   task automatic ack_one(input string name);
      int n;
      n = 0;
      while (!send && n < 300) begin wait_cyc(1); n++; end
      if (!send) begin
         total++; bad++;
         $display("FAIL %s: send timeout, got 0 expected 1", name);
      end
      man_ack = 1'b1;
      n = 0;
      while (send && n < 20) begin wait_cyc(1); n++; end
      if (send) begin
         total++; bad++;
         $display("FAIL %s: send stuck, got 1 expected 0", name);
      end
      man_ack = 1'b0;
      wait_cyc(2);
   endtask

   initial begin
      logic [KEYS-1:0] v;
      rows[0] = '{40'h00_0000_0020, 256, 40'h00_0000_0020, 1, 24'h000085};
      rows[1] = '{40'h0,            256, 40'h0,            1, 24'h000005};
      rows[2] = '{40'h00_0000_0080, 128, 40'h0,            0, 24'h0};
      rows[3] = '{40'h0,             64, 40'h0,            0, 24'h0};
      rows[4] = '{40'h00_0000_0080, 128, 40'h0,            0, 24'h0};
      rows[5] = '{40'h0,            256, 40'h0,            0, 24'h0};
      rows[6] = '{40'h80_0000_1001, 256, 40'h80_0000_1001, 3, 24'hA78C80};
      rows[7] = '{40'h0,            256, 40'h0,            3, 24'h270C00};

      rst = 1'b1;
      key_down = '0;
      wait_cyc(3);
      chk("reset_send", 64'(send), 64'(0));
      chk("reset_data", 64'(data), 64'(0));
      chk("reset_stable", 64'(stable_keys), 64'(0));
      chk("reset_level", 64'(fifo_level), 64'(0));
      chk("reset_overflow", 64'(overflow), 64'(0));
      rst = 1'b0;

      for (int r = 0; r < 8; r++) begin
         key_down = rows[r].keys;
         for (int j = 0; j < rows[r].n_ev; j++) exp_q.push_back(rows[r].evs[8*j +: 8]);
         wait_cyc(rows[r].cycles);
         chk($sformatf("row%0d_stable", r), 64'(stable_keys), 64'(rows[r].exp_stable));
         chk($sformatf("row%0d_level", r), 64'(fifo_level), 64'(0));
         compare_events($sformatf("row%0d_bytes", r));
      end
      chk("no_overflow_yet", 64'(overflow), 64'(0));

      // Long acknowledge: two events queued, send_done held high for 10 cycles.
      auto_ack = 1'b0;
      key_down = 40'h6;
      exp_q.push_back(8'h81);
      exp_q.push_back(8'h82);
      wait_cyc(256);
      chk("long_send_hi", 64'(send), 64'(1));
      chk("long_data1", 64'(data), 64'(8'h81));
      chk("long_level", 64'(fifo_level), 64'(1));
      man_ack = 1'b1;
      wait_cyc(10);
      chk("long_send_lo", 64'(send), 64'(0));
      chk("long_one_byte", 64'(got_q.size()), 64'(1));
      man_ack = 1'b0;
      wait_cyc(5);
      chk("long_send2_hi", 64'(send), 64'(1));
      chk("long_data2", 64'(data), 64'(8'h82));
      ack_one("long_ack2");
      compare_events("long_bytes");
      auto_ack = 1'b1;
      key_down = '0;
      exp_q.push_back(8'h01);
      exp_q.push_back(8'h02);
      wait_cyc(256);
      compare_events("long_release_bytes");

      // Overflow: six presses on one tick, nothing acknowledged.  Key 0 is
      // already loaded into the sender, keys 1..4 fill the FIFO, key 5 is dropped.
      auto_ack = 1'b0;
      v = '0;
      for (int k = 0; k < 6; k++) begin
         v[k] = 1'b1;
         exp_q.push_back(8'h80 | 8'(k));
      end
      void'(exp_q.pop_back());
      key_down = v;
      wait_cyc(256);
      chk("ovf_level", 64'(fifo_level), 64'(DEPTH));
      chk("ovf_flag", 64'(overflow), 64'(1));
      chk("ovf_stable", 64'(stable_keys), 64'(40'h3F));
      chk("ovf_data", 64'(data), 64'(8'h80));
      ack_one("ovf_ack0");
      ack_one("ovf_ack1");
      wait_cyc(6);
      chk("pre_rst_send", 64'(send), 64'(1));
      chk("pre_rst_data", 64'(data), 64'(8'h82));
      chk("pre_rst_level", 64'(fifo_level), 64'(2));
      chk("ovf_sticky", 64'(overflow), 64'(1));
      // The two bytes still queued are abandoned by the reset below.
      void'(exp_q.pop_back());
      void'(exp_q.pop_back());
      compare_events("ovf_bytes");

      // Reset mid-transfer.
      #2 rst = 1'b1;
      key_down = '0;
      #1;
      chk("rst_send", 64'(send), 64'(0));
      chk("rst_data", 64'(data), 64'(0));
      chk("rst_level", 64'(fifo_level), 64'(0));
      chk("rst_overflow", 64'(overflow), 64'(0));
      chk("rst_stable", 64'(stable_keys), 64'(0));
      wait_cyc(3);
      rst = 1'b0;
      auto_ack = 1'b1;
      wait_cyc(300);
      chk("post_rst_send", 64'(send), 64'(0));
      chk("post_rst_level", 64'(fifo_level), 64'(0));
      compare_events("post_rst_bytes");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
